// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECUTER, S_EXECUTEI, S_ALUWB, S_JAL, S_BEQ
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_REG   = 2'b10;

   localparam logic [1:0] SRCB_WDATA = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction fields and flags in, datapath control lines out.
interface multicycle_controller_if;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [2:0] ALUControl;
   logic [1:0] ImmSrc;
   logic       illegal_op;

   modport slave (
      input  op, funct3, funct7b5, zero,
      output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal_op
   );

   modport master (
      output op, funct3, funct7b5, zero,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal_op
   );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps ALUOp plus instruction function fields onto the ALU operation code.
module alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic [1:0] ALUOp,
   input  logic [2:0] funct3,
   input  logic       op5,
   input  logic       funct7b5,
   output logic [2:0] ALUControl
);
   always_comb begin
      ALUControl = ALU_ADD;
      case (ALUOp)
         ALUOP_ADD: ALUControl = ALU_ADD;
         ALUOP_SUB: ALUControl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // funct7b5 alone is an immediate bit for addi; only R-type subtracts
               3'b000:  ALUControl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  ALUControl = ALU_SLT;
               3'b110:  ALUControl = ALU_OR;
               3'b111:  ALUControl = ALU_AND;
               default: ALUControl = ALU_ADD;
            endcase
         end
         default: ALUControl = ALU_ADD;
      endcase
   end
endmodule

// File: rtl/multicycle_controller.sv
// Moore main FSM for the multicycle RV32I core plus immediate-format decode.
module multicycle_controller
   import riscv_ctrl_pkg::*;
(
   input logic                     clk,
   input logic                     reset,
   multicycle_controller_if.slave  bus
);
   state_t     state_reg, state_next;
   logic       pc_update, branch;
   logic [1:0] alu_op;

   always_ff @(posedge clk) begin
      if (reset) state_reg <= S_FETCH;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next     = state_reg;
      pc_update      = 1'b0;
      branch         = 1'b0;
      alu_op         = ALUOP_ADD;
      bus.AdrSrc     = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.IRWrite    = 1'b0;
      bus.RegWrite   = 1'b0;
      bus.ResultSrc  = RES_ALUOUT;
      bus.ALUSrcA    = SRCA_PC;
      bus.ALUSrcB    = SRCB_WDATA;
      bus.illegal_op = 1'b0;
      case (state_reg)
         S_FETCH: begin
            bus.IRWrite   = 1'b1;
            pc_update     = 1'b1;
            bus.ALUSrcB   = SRCB_FOUR;
            bus.ResultSrc = RES_ALURESULT;
            state_next    = S_DECODE;
         end
         S_DECODE: begin
            bus.ALUSrcA = SRCA_OLDPC;
            bus.ALUSrcB = SRCB_IMM;
            case (bus.op)
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_R:         state_next = S_EXECUTER;
               OP_I:         state_next = S_EXECUTEI;
               OP_JAL:       state_next = S_JAL;
               OP_BEQ:       state_next = S_BEQ;
               default: begin
                  state_next     = S_FETCH;
                  bus.illegal_op = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            bus.ALUSrcA = SRCA_REG;
            bus.ALUSrcB = SRCB_IMM;
            state_next  = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            bus.AdrSrc = 1'b1;
            state_next = S_MEMWB;
         end
         S_MEMWB: begin
            bus.ResultSrc = RES_DATA;
            bus.RegWrite  = 1'b1;
            state_next    = S_FETCH;
         end
         S_MEMWRITE: begin
            bus.AdrSrc   = 1'b1;
            bus.MemWrite = 1'b1;
            state_next   = S_FETCH;
         end
         S_EXECUTER: begin
            bus.ALUSrcA = SRCA_REG;
            alu_op      = ALUOP_FUNCT;
            state_next  = S_ALUWB;
         end
         S_EXECUTEI: begin
            bus.ALUSrcA = SRCA_REG;
            bus.ALUSrcB = SRCB_IMM;
            alu_op      = ALUOP_FUNCT;
            state_next  = S_ALUWB;
         end
         S_ALUWB: begin
            bus.RegWrite = 1'b1;
            state_next   = S_FETCH;
         end
         // OldPC+4 goes to rd via ALUWB while the target computed in DECODE loads the PC
         S_JAL: begin
            bus.ALUSrcA = SRCA_OLDPC;
            bus.ALUSrcB = SRCB_FOUR;
            pc_update   = 1'b1;
            state_next  = S_ALUWB;
         end
         S_BEQ: begin
            bus.ALUSrcA = SRCA_REG;
            alu_op      = ALUOP_SUB;
            branch      = 1'b1;
            state_next  = S_FETCH;
         end
         default: state_next = S_FETCH;
      endcase
   end

   assign bus.PCWrite = pc_update | (branch & bus.zero);

   always_comb begin
      case (bus.op)
         OP_SW:   bus.ImmSrc = IMM_S;
         OP_BEQ:  bus.ImmSrc = IMM_B;
         OP_JAL:  bus.ImmSrc = IMM_J;
         default: bus.ImmSrc = IMM_I;
      endcase
   end

   alu_decoder u_alu_decoder (
      .ALUOp      (alu_op),
      .funct3     (bus.funct3),
      .op5        (bus.op[5]),
      .funct7b5   (bus.funct7b5),
      .ALUControl (bus.ALUControl)
   );
endmodule
